// File: rtl/instr_fetch_decode_pkg.sv
// Shared TPU ISA definitions: instruction layout, legal func/opcode pairs,
// memory-space one-hot codes and the HALT word.
package instr_fetch_decode_pkg;

  localparam int unsigned ISA_IW = 32;

  localparam logic [7:0] FO_MOVE      = 8'h11;
  localparam logic [7:0] FO_PRELOAD_A = 8'h12;
  localparam logic [7:0] FO_PE_COMP   = 8'h14;
  localparam logic [7:0] FO_PRELOAD_B = 8'h22;
  localparam logic [7:0] FO_HALT      = 8'hFF;

  localparam logic [3:0] FUNC_HALT = 4'hF;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  localparam logic [ISA_IW-1:0] HALT_WORD = 32'hFF00_0000;

  typedef enum logic [3:0] {
    SPACE_SHM   = 4'b0001,
    SPACE_INBUF = 4'b0010,
    SPACE_WBUF  = 4'b0100
  } space_e;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] opcode;
    logic [9:0] rs1;
    logic [9:0] rs2;
    logic [3:0] rsvd;
  } instr_t;

  function automatic logic space_ok(input logic [3:0] sp);
    return (sp == SPACE_SHM) || (sp == SPACE_INBUF) || (sp == SPACE_WBUF);
  endfunction

  // Operand spaces only constrain MOVE; the other legal ops ignore them.
  function automatic logic instr_legal(input logic [7:0] fo,
                                       input logic [3:0] sp1,
                                       input logic [3:0] sp2);
    case (fo)
      FO_PRELOAD_A, FO_PRELOAD_B, FO_PE_COMP, FO_HALT: return 1'b1;
      FO_MOVE:                                          return space_ok(sp1) && space_ok(sp2);
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Host program-load, controller fetch/decode strobes and decoded-field bundle.
interface instr_fetch_decode_if;
  import instr_fetch_decode_pkg::*;

  logic              prog_we;
  logic [7:0]        prog_addr;
  logic [ISA_IW-1:0] prog_wdata;
  logic [7:0]        pc;
  logic              INSBUF_en;
  logic              DECODER_en;
  logic              err_clr;
  logic [3:0]        func;
  logic [3:0]        opcode;
  logic [9:0]        rs1;
  logic [9:0]        rs2;
  logic              illegal;
  logic [15:0]       decode_cnt;

  modport master (
    output prog_we, prog_addr, prog_wdata, pc, INSBUF_en, DECODER_en, err_clr,
    input  func, opcode, rs1, rs2, illegal, decode_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, pc, INSBUF_en, DECODER_en, err_clr,
    output func, opcode, rs1, rs2, illegal, decode_cnt
  );

endinterface

// File: rtl/instr_fetch_decode_mem.sv
// DEPTH x IW instruction RAM: one write port, one synchronous read-first read port.
// Out-of-range reads return OOB_WORD; out-of-range writes are dropped.
module instr_fetch_decode_mem #(
  parameter int unsigned     DEPTH    = 256,
  parameter int unsigned     IW       = 32,
  parameter logic [IW-1:0]   OOB_WORD = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [7:0]    i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [7:0]    i_raddr,
  output logic [IW-1:0] o_rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_rdata;
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign w_wr_ok = 32'(i_waddr) < DEPTH;
  assign w_rd_ok = 32'(i_raddr) < DEPTH;

  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) r_mem[i_waddr[AW-1:0]] <= i_wdata;
  end

  // Separate read register keeps read-first ordering and gives ir its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= w_rd_ok ? r_mem[i_raddr[AW-1:0]] : OOB_WORD;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction store plus fetch/decode stage feeding the TPU controller.
// Illegal encodings, or a decode with no fetched word, decode as HALT and raise sticky illegal.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = ISA_IW
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_decode_if.slave bus
);

  logic [IW-1:0] w_ir;
  instr_t        w_ins;
  logic [3:0]    w_unused_rsvd;
  logic          w_legal;

  logic          r_ir_valid;
  logic [3:0]    r_func;
  logic [3:0]    r_opcode;
  logic [9:0]    r_rs1;
  logic [9:0]    r_rs2;
  logic          r_illegal;
  logic [15:0]   r_decode_cnt;

  instr_fetch_decode_mem #(
    .DEPTH    (DEPTH),
    .IW       (IW),
    .OOB_WORD (HALT_WORD)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .i_we    (bus.prog_we),
    .i_waddr (bus.prog_addr),
    .i_wdata (bus.prog_wdata),
    .i_re    (bus.INSBUF_en),
    .i_raddr (bus.pc),
    .o_rdata (w_ir)
  );

  assign w_ins         = w_ir;
  assign w_unused_rsvd = w_ins.rsvd;
  assign w_legal       = r_ir_valid &&
                         instr_legal({w_ins.func, w_ins.opcode}, w_ins.rs1[9:6], w_ins.rs2[9:6]);

  // A fetch in the same cycle as a decode refills ir, so ir_valid stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_ir_valid <= 1'b0;
    else if (bus.INSBUF_en)   r_ir_valid <= 1'b1;
    else if (bus.DECODER_en)  r_ir_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_func       <= FUNC_HALT;
      r_opcode     <= OPC_HALT;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_decode_cnt <= '0;
    end else if (bus.DECODER_en) begin
      r_decode_cnt <= r_decode_cnt + 16'd1;
      if (w_legal) begin
        r_func   <= w_ins.func;
        r_opcode <= w_ins.opcode;
        r_rs1    <= w_ins.rs1;
        r_rs2    <= w_ins.rs2;
      end else begin
        r_func   <= FUNC_HALT;
        r_opcode <= OPC_HALT;
        r_rs1    <= '0;
        r_rs2    <= '0;
      end
    end
  end

  // Set has priority over err_clr so a same-cycle illegal event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_illegal <= 1'b0;
    else if (bus.DECODER_en && !w_legal)    r_illegal <= 1'b1;
    else if (bus.err_clr)                   r_illegal <= 1'b0;
  end

  assign bus.func       = r_func;
  assign bus.opcode     = r_opcode;
  assign bus.rs1        = r_rs1;
  assign bus.rs2        = r_rs2;
  assign bus.illegal    = r_illegal;
  assign bus.decode_cnt = r_decode_cnt;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode (DEPTH=128) against a behavioural model.
module tb_instr_fetch_decode;

  localparam int          DEPTH    = 128;
  localparam logic [27:0] HALT_OUT = 28'hFF00000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_fetch_decode_if bus();

  instr_fetch_decode #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_ir;
  bit          m_valid;
  logic [27:0] m_out;
  bit          m_illegal;
  logic [15:0] m_cnt;

  function automatic logic [27:0] obs();
    return {bus.func, bus.opcode, bus.rs1, bus.rs2};
  endfunction

  function automatic bit ref_legal(logic [31:0] w);
    bit ok1;
    bit ok2;
    ok1 = (w[23:20] == 4'b0001) || (w[23:20] == 4'b0010) || (w[23:20] == 4'b0100);
    ok2 = (w[13:10] == 4'b0001) || (w[13:10] == 4'b0010) || (w[13:10] == 4'b0100);
    case (w[31:24])
      8'h12, 8'h22, 8'h14, 8'hFF: return 1'b1;
      8'h11:                      return ok1 && ok2;
      default:                    return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_ir = '0; m_valid = 0; m_out = HALT_OUT; m_illegal = 0; m_cnt = '0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    bit set_ill;
    set_ill = 0;
    if (bus.DECODER_en) begin
      m_cnt = m_cnt + 16'd1;
      if (m_valid && ref_legal(m_ir)) m_out = m_ir[31:4];
      else begin m_out = HALT_OUT; set_ill = 1; end
    end
    if (set_ill)          m_illegal = 1;
    else if (bus.err_clr) m_illegal = 0;
    if (bus.INSBUF_en) begin
      m_ir    = (int'(bus.pc) < DEPTH) ? m_mem[bus.pc] : 32'hFF00_0000;
      m_valid = 1;
    end else if (bus.DECODER_en) m_valid = 0;
    if (bus.prog_we && int'(bus.prog_addr) < DEPTH) m_mem[bus.prog_addr] = bus.prog_wdata;
  endtask

  task automatic idle();
    bus.prog_we = 0; bus.prog_addr = '0; bus.prog_wdata = '0; bus.pc = '0;
    bus.INSBUF_en = 0; bus.DECODER_en = 0; bus.err_clr = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
    bus.prog_we = 1; bus.prog_addr = a; bus.prog_wdata = d;
    cycle();
    bus.prog_we = 0;
  endtask

  task automatic fetch(input logic [7:0] p);
    bus.INSBUF_en = 1; bus.pc = p;
    cycle();
    bus.INSBUF_en = 0;
  endtask

  task automatic decode();
    bus.DECODER_en = 1;
    cycle();
    bus.DECODER_en = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    reset = 1;
    #1;
    model_reset();
    n_tests++; if (obs() !== HALT_OUT) begin n_fail++; $display("FAIL reset_fields got %h exp %h", obs(), HALT_OUT); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", bus.illegal); end
    n_tests++; if (bus.decode_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", bus.decode_cnt); end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_basic_decode();
    prog_write(8'd0, 32'h1211_0040);
    fetch(8'd0);
    decode();
    n_tests++; if (obs() !== {4'h1, 4'h2, 10'h044, 10'h004}) begin n_fail++; $display("FAIL basic_fields got %h exp %h", obs(), {4'h1, 4'h2, 10'h044, 10'h004}); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL basic_illegal got %b exp 0", bus.illegal); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_tests++; if (obs() !== 28'h1211004) begin n_fail++; $display("FAIL basic_hold cyc=%0d got %h exp 1211004", i, obs()); end
    end
  endtask

  task automatic test_illegal_move();
    logic [31:0] bad_w;
    logic [31:0] good_w;
    bad_w  = {8'h11, 10'h044, 4'b0011, 6'h05, 4'h0};
    good_w = {8'h11, 4'b0100, 6'h03, 4'b0010, 6'h3F, 4'h0};
    prog_write(8'd1, bad_w);
    prog_write(8'd2, good_w);
    fetch(8'd1);
    decode();
    n_tests++; if (obs() !== HALT_OUT) begin n_fail++; $display("FAIL badmove_fields got %h exp %h", obs(), HALT_OUT); end
    n_tests++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL badmove_illegal got %b exp 1", bus.illegal); end
    bus.err_clr = 1; cycle(); bus.err_clr = 0;
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b exp 0", bus.illegal); end
    fetch(8'd2);
    decode();
    n_tests++; if (obs() !== good_w[31:4]) begin n_fail++; $display("FAIL goodmove_fields got %h exp %h", obs(), good_w[31:4]); end
    fetch(8'd1);
    bus.err_clr = 1; bus.DECODER_en = 1; cycle(); bus.err_clr = 0; bus.DECODER_en = 0;
    n_tests++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got %b exp 1", bus.illegal); end
    n_tests++; if (obs() !== HALT_OUT) begin n_fail++; $display("FAIL set_beats_clr_fields got %h exp %h", obs(), HALT_OUT); end
  endtask

  task automatic test_no_fetch();
    test_reset();
    decode();
    n_tests++; if (obs() !== HALT_OUT) begin n_fail++; $display("FAIL nofetch_fields got %h exp %h", obs(), HALT_OUT); end
    n_tests++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL nofetch_illegal got %b exp 1", bus.illegal); end
    n_tests++; if (bus.decode_cnt !== 16'd1) begin n_fail++; $display("FAIL nofetch_cnt got %0d exp 1", bus.decode_cnt); end
  endtask

  task automatic test_read_first();
    logic [31:0] r;
    logic [31:0] old_w;
    logic [31:0] new_w;
    r = $urandom(); old_w = {8'h14, r[23:0]};
    r = $urandom(); new_w = {8'h22, r[23:0]};
    bus.err_clr = 1;
    prog_write(8'd5, old_w);
    bus.err_clr = 0;
    bus.prog_we = 1; bus.prog_addr = 8'd5; bus.prog_wdata = new_w;
    bus.INSBUF_en = 1; bus.pc = 8'd5;
    cycle();
    bus.prog_we = 0; bus.INSBUF_en = 0;
    decode();
    n_tests++; if (obs() !== old_w[31:4]) begin n_fail++; $display("FAIL read_first_old got %h exp %h", obs(), old_w[31:4]); end
    prog_write(8'd133, 32'h1111_1110);
    fetch(8'd5);
    decode();
    n_tests++; if (obs() !== new_w[31:4]) begin n_fail++; $display("FAIL read_first_new got %h exp %h", obs(), new_w[31:4]); end
    fetch(8'd200);
    decode();
    n_tests++; if (obs() !== HALT_OUT) begin n_fail++; $display("FAIL pc_oob got %h exp %h", obs(), HALT_OUT); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL pc_oob_illegal got %b exp 0", bus.illegal); end
    fetch(8'd5);
    bus.INSBUF_en = 1; bus.pc = 8'd0; bus.DECODER_en = 1;
    cycle();
    bus.INSBUF_en = 0; bus.DECODER_en = 0;
    n_tests++; if (obs() !== new_w[31:4]) begin n_fail++; $display("FAIL overlap_old_ir got %h exp %h", obs(), new_w[31:4]); end
    decode();
    n_tests++; if (obs() !== 28'h1211004) begin n_fail++; $display("FAIL overlap_new_ir got %h exp 1211004", obs()); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL overlap_illegal got %b exp 0", bus.illegal); end
  endtask

  task automatic test_program();
    logic [31:0] prog [4];
    int          pc_v;
    bit          halted;
    prog[0] = {8'h11, 4'b0010, 6'h01, 4'b0100, 6'h02, 4'h0};
    prog[1] = {8'h12, 4'b0001, 6'h10, 4'b0010, 6'h11, 4'h0};
    prog[2] = {8'h14, 4'b0100, 6'h20, 4'b0001, 6'h21, 4'h0};
    prog[3] = 32'hFF00_0000;
    test_reset();
    for (int i = 0; i < 4; i++) prog_write(8'(i), prog[i]);
    pc_v = 0; halted = 0;
    for (int k = 0; k < 16 && !halted; k++) begin
      fetch(8'(pc_v));
      decode();
      n_tests++; if (obs() !== prog[pc_v][31:4]) begin n_fail++; $display("FAIL prog_fields pc=%0d got %h exp %h", pc_v, obs(), prog[pc_v][31:4]); end
      if (bus.func == 4'hF && bus.opcode == 4'hF) halted = 1;
      else pc_v++;
    end
    n_tests++; if (!halted || pc_v != 3) begin n_fail++; $display("FAIL prog_halt_pc got halted=%0d pc=%0d exp halted=1 pc=3", halted, pc_v); end
    n_tests++; if (bus.decode_cnt !== 16'd4) begin n_fail++; $display("FAIL prog_cnt got %0d exp 4", bus.decode_cnt); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL prog_illegal got %b exp 0", bus.illegal); end
  endtask

  task automatic test_random();
    logic [7:0]  fos [4];
    logic [31:0] r;
    logic [31:0] w;
    logic [3:0]  sp1;
    logic [3:0]  sp2;
    fos[0] = 8'h12; fos[1] = 8'h22; fos[2] = 8'h14; fos[3] = 8'hFF;
    test_reset();
    for (int a = 0; a < DEPTH; a++) begin
      r   = $urandom();
      sp1 = 4'b0001 << $urandom_range(0, 2);
      sp2 = 4'b0001 << $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0:       w = {fos[$urandom_range(0, 3)], r[23:0]};
        1:       w = {8'h11, sp1, r[5:0], sp2, r[11:6], r[15:12]};
        2:       w = {8'h11, r[23:0]};
        3:       w = r;
        default: w = {4'($urandom_range(1, 2)), r[27:0]};
      endcase
      prog_write(8'(a), w);
    end
    for (int i = 0; i < 400; i++) begin
      bus.INSBUF_en  = 1'($urandom_range(0, 1));
      bus.DECODER_en = 1'($urandom_range(0, 1));
      bus.err_clr    = ($urandom_range(0, 7) == 0);
      bus.pc         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
      bus.prog_we    = ($urandom_range(0, 7) == 0);
      bus.prog_addr  = 8'($urandom_range(0, 255));
      bus.prog_wdata = $urandom();
      cycle();
      n_tests++; if (obs() !== m_out) begin n_fail++; $display("FAIL rand_fields cyc=%0d got %h exp %h", i, obs(), m_out); end
      n_tests++; if (bus.illegal !== m_illegal) begin n_fail++; $display("FAIL rand_illegal cyc=%0d got %b exp %b", i, bus.illegal, m_illegal); end
      n_tests++; if (bus.decode_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt cyc=%0d got %0d exp %0d", i, bus.decode_cnt, m_cnt); end
    end
    idle();
  endtask

  task automatic test_cnt_wrap();
    test_reset();
    bus.DECODER_en = 1;
    for (int i = 0; i < 65535; i++) cycle();
    n_tests++; if (bus.decode_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_max got %h exp FFFF", bus.decode_cnt); end
    cycle();
    bus.DECODER_en = 0;
    n_tests++; if (bus.decode_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap got %h exp 0000", bus.decode_cnt); end
    n_tests++; if (bus.decode_cnt !== m_cnt) begin n_fail++; $display("FAIL cnt_wrap_model got %h exp %h", bus.decode_cnt, m_cnt); end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_basic_decode();
    test_reset();
    test_illegal_move();
    test_no_fetch();
    test_read_first();
    test_program();
    test_random();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
